hpm_event_ctrl: RTL and testbench

HPM_EVENT_CTRL -- requirements
Module: hpm_event_ctrl

---
 rtl/hpm_pkg.sv | 27 ++
 rtl/hpm_event_ctrl_if.sv | 20 ++
 rtl/hpm_event_slice.sv | 69 ++++++
 rtl/hpm_event_ctrl.sv | 148 ++++++++++++++
 tb/tb_hpm_event_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hpm_pkg.sv
// Shared definitions for the HPM event controller: CSR map, mhpmevent layout, CSR FSM states.
package hpm_pkg;

    localparam logic [11:0] CSR_MCOUNTINHIBIT  = 12'h320;
    localparam logic [11:0] CSR_MHPMEVENT_BASE = 12'h323;

    localparam int MHPMEVENT_SEL_LSB = 0;
    localparam int MHPMEVENT_SEL_W   = 8;
    localparam int MHPMEVENT_OF_BIT  = 31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RESP = 2'd1,
        ST_WAIT = 2'd2
    } csr_state_e;

    // Assemble the architectural mhpmevent view; unimplemented bits read 0.
    function automatic logic [31:0] mhpmevent_pack(input logic of_bit,
                                                   input logic [MHPMEVENT_SEL_W-1:0] sel);
        logic [31:0] v;
        v = '0;
        v[MHPMEVENT_OF_BIT] = of_bit;
        v[MHPMEVENT_SEL_LSB +: MHPMEVENT_SEL_W] = sel;
        return v;
    endfunction

endpackage

// File: rtl/hpm_event_ctrl_if.sv
// CSR request/response bundle between a CSR requester (master) and the HPM controller (slave).
interface hpm_event_ctrl_if;
    logic        csr_active;
    logic        csr_write;
    logic [11:0] csr_addr;
    logic [31:0] value_in;
    logic [31:0] value_out;
    logic        ack;
    logic        invalid_csr;

    modport master (
        output csr_active, csr_write, csr_addr, value_in,
        input  value_out, ack, invalid_csr
    );

    modport slave (
        input  csr_active, csr_write, csr_addr, value_in,
        output value_out, ack, invalid_csr
    );
endinterface

// File: rtl/hpm_event_slice.sv
// One counter's mhpmevent register (SEL/OF) and its registered increment enable.
module hpm_event_slice
    import hpm_pkg::*;
#(
    parameter int NUM_EVENTS = 8
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       wr_en_i,
    input  logic [MHPMEVENT_SEL_W-1:0] wsel_i,
    input  logic                       wof_i,
    input  logic [NUM_EVENTS-1:0]      event_bus_i,
    input  logic                       inhibit_i,
    input  logic                       rollover_i,
    output logic [MHPMEVENT_SEL_W-1:0] sel_o,
    output logic                       of_o,
    output logic                       enable_o
);

    logic [MHPMEVENT_SEL_W-1:0] sel_q, sel_d;
    logic                       of_q, of_d;
    logic                       enable_q;
    logic                       hit;

    // Next SEL/OF: SEL is WARL (out-of-range selects collapse to 0), rollover beats a software clear.
    always_comb begin
        sel_d = sel_q;
        of_d  = of_q;
        if (wr_en_i) begin
            if (int'(wsel_i) >= 1 && int'(wsel_i) <= NUM_EVENTS) begin
                sel_d = wsel_i;
            end else begin
                sel_d = '0;
            end
            of_d = wof_i;
        end
        if (rollover_i) begin
            of_d = 1'b1;
        end
    end

    // Select the event line named by SEL (SEL=k watches event_bus[k-1], SEL=0 watches nothing).
    always_comb begin
        hit = 1'b0;
        for (int e = 0; e < NUM_EVENTS; e++) begin
            if (int'(sel_q) == e + 1) begin
                hit = event_bus_i[e];
            end
        end
    end

    // Register SEL/OF and the per-counter enable.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sel_q    <= '0;
            of_q     <= 1'b0;
            enable_q <= 1'b0;
        end else begin
            sel_q    <= sel_d;
            of_q     <= of_d;
            enable_q <= hit && !inhibit_i;
        end
    end

    assign sel_o    = sel_q;
    assign of_o     = of_q;
    assign enable_o = enable_q;

endmodule

// File: rtl/hpm_event_ctrl.sv
// HPM event controller: CSR front end for mcountinhibit/mhpmevent, per-counter enables, overflow IRQ.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for csr_active; latches addr/data/write on request
// ST_RESP | one-cycle response (ack or invalid_csr); write commits at exit
// ST_WAIT | waiting for the requester to drop csr_active
module hpm_event_ctrl
    import hpm_pkg::*;
#(
    parameter int NUM_COUNTERS = 2,
    parameter int NUM_EVENTS   = 8
) (
    input  logic                    clk,
    input  logic                    n_rst,
    hpm_event_ctrl_if.slave         csr,
    input  logic [NUM_EVENTS-1:0]   event_bus,
    input  logic [NUM_COUNTERS-1:0] rollover_in,
    output logic [NUM_COUNTERS-1:0] enable_array,
    output logic                    ovf_irq
);

    csr_state_e               state_q;
    logic [11:0]              addr_q;
    logic [31:0]              data_q;
    logic                     write_q;
    logic                     ack_q;
    logic                     invalid_q;
    logic [31:0]              value_out_q;
    logic [NUM_COUNTERS-1:0]  inhibit_q, inhibit_d;
    logic                     ovf_irq_q;

    logic                     owned_in;
    logic [31:0]              rd_val;
    logic                     wr_commit;
    logic [NUM_COUNTERS-1:0]  wr_ev;
    logic [MHPMEVENT_SEL_W-1:0] sel_w [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0]  of_w;
    logic                     unused_data;

    // Not every write-data bit maps to a register field.
    assign unused_data = ^data_q;

    // Decode the incoming address and form its current (pre-write) read value.
    always_comb begin
        owned_in = 1'b0;
        rd_val   = '0;
        if (csr.csr_addr == CSR_MCOUNTINHIBIT) begin
            owned_in = 1'b1;
            rd_val   = 32'(inhibit_q);
        end
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (csr.csr_addr == CSR_MHPMEVENT_BASE + 12'(i)) begin
                owned_in = 1'b1;
                rd_val   = mhpmevent_pack(of_w[i], sel_w[i]);
            end
        end
    end

    // ack_q doubles as "latched address is owned", so it qualifies the commit.
    assign wr_commit = (state_q == ST_RESP) && write_q && ack_q;

    // Next inhibit mask on a committed write to mcountinhibit.
    always_comb begin
        inhibit_d = inhibit_q;
        if (wr_commit && addr_q == CSR_MCOUNTINHIBIT) begin
            inhibit_d = data_q[NUM_COUNTERS-1:0];
        end
    end

    // CSR handshake FSM with registered response outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            write_q     <= 1'b0;
            ack_q       <= 1'b0;
            invalid_q   <= 1'b0;
            value_out_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (csr.csr_active) begin
                        addr_q      <= csr.csr_addr;
                        data_q      <= csr.value_in;
                        write_q     <= csr.csr_write;
                        ack_q       <= owned_in;
                        invalid_q   <= !owned_in;
                        value_out_q <= owned_in ? rd_val : 32'h0;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    ack_q       <= 1'b0;
                    invalid_q   <= 1'b0;
                    value_out_q <= '0;
                    state_q     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!csr.csr_active) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Inhibit mask and overflow interrupt registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            inhibit_q <= '0;
            ovf_irq_q <= 1'b0;
        end else begin
            inhibit_q <= inhibit_d;
            ovf_irq_q <= |of_w;
        end
    end

    for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_slice
        assign wr_ev[i] = wr_commit && (addr_q == CSR_MHPMEVENT_BASE + 12'(i));

        hpm_event_slice #(
            .NUM_EVENTS (NUM_EVENTS)
        ) u_slice (
            .clk         (clk),
            .n_rst       (n_rst),
            .wr_en_i     (wr_ev[i]),
            .wsel_i      (data_q[MHPMEVENT_SEL_LSB +: MHPMEVENT_SEL_W]),
            .wof_i       (data_q[MHPMEVENT_OF_BIT]),
            .event_bus_i (event_bus),
            .inhibit_i   (inhibit_q[i]),
            .rollover_i  (rollover_in[i]),
            .sel_o       (sel_w[i]),
            .of_o        (of_w[i]),
            .enable_o    (enable_array[i])
        );
    end

    assign csr.ack         = ack_q;
    assign csr.invalid_csr = invalid_q;
    assign csr.value_out   = value_out_q;
    assign ovf_irq         = ovf_irq_q;

endmodule

// File: tb/tb_hpm_event_ctrl.sv
// Directed plus randomized bench for hpm_event_ctrl against a behavioural register model.
module tb_hpm_event_ctrl;

    localparam int NC = 2;
    localparam int NE = 8;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic [NE-1:0] event_bus;
    logic [NC-1:0] rollover_in;
    logic [NC-1:0] enable_array;
    logic          ovf_irq;

    always #5 clk = ~clk;

    hpm_event_ctrl_if csr_if ();

    hpm_event_ctrl #(
        .NUM_COUNTERS (NC),
        .NUM_EVENTS   (NE)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .csr          (csr_if.slave),
        .event_bus    (event_bus),
        .rollover_in  (rollover_in),
        .enable_array (enable_array),
        .ovf_irq      (ovf_irq)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0]    sel_m [NC];
    logic          of_m  [NC];
    logic [NC-1:0] inh_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NC; i++) begin
            sel_m[i] = '0;
            of_m[i]  = 1'b0;
        end
        inh_m = '0;
    endfunction

    function automatic bit model_owned(input logic [11:0] a);
        return (a == 12'h320) || (int'(a) >= 'h323 && int'(a) < 'h323 + NC);
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        if (a == 12'h320) return 32'(inh_m);
        for (int i = 0; i < NC; i++)
            if (int'(a) == 'h323 + i) return {of_m[i], 23'b0, sel_m[i]};
        return 32'h0;
    endfunction

    function automatic void model_write(input logic [11:0] a, input logic [31:0] d);
        if (a == 12'h320) inh_m = d[NC-1:0];
        for (int i = 0; i < NC; i++) begin
            if (int'(a) == 'h323 + i) begin
                sel_m[i] = (int'(d[7:0]) >= 1 && int'(d[7:0]) <= NE) ? d[7:0] : 8'h0;
                of_m[i]  = d[31];
            end
        end
    endfunction

    // One cycle of event/rollover stimulus, checking the enables and IRQ that follow it.
    task automatic step(input logic [NE-1:0] ev, input logic [NC-1:0] ro);
        logic [NC-1:0] exp_en;
        logic          irq_exp;
        int            s;
        irq_exp = 1'b0;
        for (int i = 0; i < NC; i++) irq_exp |= of_m[i];
        event_bus   = ev;
        rollover_in = ro;
        @(posedge clk); #1;
        for (int i = 0; i < NC; i++) begin
            s = int'(sel_m[i]);
            exp_en[i] = (s != 0) && ev[s-1] && !inh_m[i];
        end
        check("enable_array", 32'(enable_array), 32'(exp_en));
        check("ovf_irq", 32'(ovf_irq), 32'(irq_exp));
        for (int i = 0; i < NC; i++) if (ro[i]) of_m[i] = 1'b1;
        event_bus   = '0;
        rollover_in = '0;
    endtask

    task automatic csr_xfer(input bit w, input logic [11:0] a, input logic [31:0] d, input int hold,
                            input logic [NC-1:0] ro_resp,
                            output int n_ack, output int n_inv, output logic [31:0] rd);
        n_ack = 0;
        n_inv = 0;
        rd    = '0;
        csr_if.csr_active = 1'b1;
        csr_if.csr_write  = w;
        csr_if.csr_addr   = a;
        csr_if.value_in   = d;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            if (csr_if.ack) begin n_ack++; rd = csr_if.value_out; end
            if (csr_if.invalid_csr) n_inv++;
            rollover_in = (c == 0) ? ro_resp : '0;
        end
        csr_if.csr_active = 1'b0;
        rollover_in = '0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            if (csr_if.ack) n_ack++;
            if (csr_if.invalid_csr) n_inv++;
        end
        if (w && n_ack > 0) model_write(a, d);
        for (int i = 0; i < NC; i++) if (ro_resp[i]) of_m[i] = 1'b1;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [NC-1:0] ro_resp);
        int n_ack, n_inv;
        logic [31:0] rd;
        csr_xfer(1'b1, a, d, 3, ro_resp, n_ack, n_inv, rd);
        check("write_ack_count", 32'(n_ack), 32'(model_owned(a)));
        check("write_inv_count", 32'(n_inv), 32'(!model_owned(a)));
    endtask

    task automatic do_read(input logic [11:0] a);
        int n_ack, n_inv;
        logic [31:0] rd;
        logic [31:0] exp;
        exp = model_read(a);
        csr_xfer(1'b0, a, 32'hDEAD_BEEF, 3, '0, n_ack, n_inv, rd);
        check("read_ack_count", 32'(n_ack), 32'd1);
        check("read_value", rd, exp);
    endtask

    initial begin
        int n_ack, n_inv;
        logic [31:0] rd;
        logic [11:0] a;
        logic [31:0] d;

        event_bus         = '0;
        rollover_in       = '0;
        csr_if.csr_active = 1'b0;
        csr_if.csr_write  = 1'b0;
        csr_if.csr_addr   = '0;
        csr_if.value_in   = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(csr_if.ack), 32'd0);
        check("rst_invalid", 32'(csr_if.invalid_csr), 32'd0);
        check("rst_value_out", csr_if.value_out, 32'd0);
        check("rst_enable", 32'(enable_array), 32'd0);
        check("rst_ovf_irq", 32'(ovf_irq), 32'd0);
        n_rst = 1'b1;
        @(posedge clk); #1;

        // Event select on counter 0, single-cycle enable
        do_write(12'h323, 32'h0000_0002, '0);
        step(8'b0000_0010, '0);
        check("sel2_enable", 32'(enable_array), 32'b01);
        step('0, '0);
        check("sel2_enable_gone", 32'(enable_array), 32'b00);

        // Inhibit blocks counter 0
        do_write(12'h320, 32'h0000_0001, '0);
        step(8'b0000_0010, '0);
        do_read(12'h320);
        check("inhibit_readback", model_read(12'h320), 32'h0000_0001);
        do_write(12'h320, 32'h0000_0000, '0);
        step(8'b0000_0010, '0);

        // WARL select
        do_write(12'h324, 32'h0000_00FF, '0);
        do_read(12'h324);
        do_write(12'h324, 32'h0000_0009, '0);
        do_read(12'h324);
        do_write(12'h324, 32'h0000_0008, '0);
        do_read(12'h324);
        step(8'b1000_0010, '0);

        // Rollover sets OF and raises the IRQ; a same-cycle clear loses
        step('0, 2'b10);
        step('0, '0);
        do_read(12'h324);
        do_write(12'h324, 32'h0000_0000, 2'b10);
        do_read(12'h324);
        step('0, '0);
        do_write(12'h324, 32'h0000_0000, '0);
        do_read(12'h324);
        step('0, '0);

        // Unowned address with a long-held request answers once
        csr_xfer(1'b0, 12'h330, 32'h0, 5, '0, n_ack, n_inv, rd);
        check("unowned_inv_count", 32'(n_inv), 32'd1);
        check("unowned_ack_count", 32'(n_ack), 32'd0);
        csr_xfer(1'b1, 12'h322, 32'hFFFF_FFFF, 5, '0, n_ack, n_inv, rd);
        check("gap_inv_count", 32'(n_inv), 32'd1);
        check("gap_ack_count", 32'(n_ack), 32'd0);
        do_read(12'h323);

        // Randomized configuration and event traffic
        for (int r = 0; r < 8; r++) begin
            a = 12'h323 + 12'($urandom_range(0, NC - 1));
            d = {1'($urandom), 23'($urandom), 8'($urandom_range(0, 12))};
            do_write(a, d, '0);
            do_write(12'h320, {30'($urandom), 2'($urandom)}, '0);
            do_read(12'h320);
            do_read(12'h323);
            do_read(12'h324);
            for (int k = 0; k < 20; k++) begin
                step(NE'($urandom), ($urandom_range(0, 7) == 0) ? NC'($urandom) : '0);
            end
        end

        // Reset during the response of a write abandons it
        do_write(12'h320, 32'h0, '0);
        csr_if.csr_active = 1'b1;
        csr_if.csr_write  = 1'b1;
        csr_if.csr_addr   = 12'h323;
        csr_if.value_in   = 32'h0000_0003;
        @(posedge clk); #1;
        n_rst = 1'b0;
        #1;
        check("rstmid_ack", 32'(csr_if.ack), 32'd0);
        check("rstmid_value_out", csr_if.value_out, 32'd0);
        check("rstmid_enable", 32'(enable_array), 32'd0);
        check("rstmid_ovf_irq", 32'(ovf_irq), 32'd0);
        csr_if.csr_active = 1'b0;
        model_reset();
        @(posedge clk); #1;
        n_rst = 1'b1;
        n_ack = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (csr_if.ack) n_ack++;
        end
        check("rstmid_no_ack", 32'(n_ack), 32'd0);
        do_read(12'h323);
        do_read(12'h320);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
